// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the control unit, MEM/WB and writeback.
package cpu_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;

   typedef enum logic [1:0] {
      WB_ALU   = 2'd0,
      WB_MEM   = 2'd1,
      WB_PC4   = 2'd2,
      WB_PCIMM = 2'd3
   } wb_sel_e;

endpackage

// File: rtl/regfile_2r1w.sv
// 32-entry architectural register file: one write port, two combinational
// read ports with write-first bypass, x0 hardwired to zero.
module regfile_2r1w
   import cpu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [REG_ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   output logic [WIDTH-1:0]      rs1_data,
   output logic [WIDTH-1:0]      rs2_data
);

   logic [WIDTH-1:0] regs [NUM_REGS];
   logic             wr_live;

   assign wr_live = wr_en && (wr_addr != '0);

   // Storage: reset clears every entry, x0 included; writes to x0 are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_live) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Read port 1: zero for x0, bypass the in-flight write, else the array.
   always_comb begin
      rs1_data = regs[rs1_addr];
      if (rs1_addr == '0) begin
         rs1_data = '0;
      end else if (wr_en && (wr_addr == rs1_addr)) begin
         rs1_data = wr_data;
      end
   end

   // Read port 2: same rules as port 1.
   always_comb begin
      rs2_data = regs[rs2_addr];
      if (rs2_addr == '0) begin
         rs2_data = '0;
      end else if (wr_en && (wr_addr == rs2_addr)) begin
         rs2_data = wr_data;
      end
   end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value from MEM/WB, commits it to the
// register file and counts retired instructions.
module wb_regfile
   import cpu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0]      mem_data_wb,
   input  logic [WIDTH-1:0]      alu_out_wb,
   input  logic [WIDTH-1:0]      pc4_wb,
   input  logic [WIDTH-1:0]      pcimm_wb,
   input  logic [REG_ADDR_W-1:0] rd_wb,
   input  logic [1:0]            wb_mux_sel_wb,
   input  logic                  reg_file_wr_wb,
   input  logic                  wb_valid_wb,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   output logic [WIDTH-1:0]      rs1_data,
   output logic [WIDTH-1:0]      rs2_data,
   output logic [WIDTH-1:0]      wb_data,
   output logic                  wb_fwd_valid,
   output logic [CNT_W-1:0]      instret
);

   // Writeback source select; independent of the write enable.
   always_comb begin
      wb_data = alu_out_wb;
      case (wb_sel_e'(wb_mux_sel_wb))
         WB_ALU:   wb_data = alu_out_wb;
         WB_MEM:   wb_data = mem_data_wb;
         WB_PC4:   wb_data = pc4_wb;
         WB_PCIMM: wb_data = pcimm_wb;
         default:  wb_data = alu_out_wb;
      endcase
   end

   assign wb_fwd_valid = reg_file_wr_wb && (rd_wb != '0);

   regfile_2r1w #(
      .WIDTH (WIDTH)
   ) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (reg_file_wr_wb),
      .wr_addr  (rd_wb),
      .wr_data  (wb_data),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data)
   );

   // Retire counter: counts valid WB slots only, wraps silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         instret <= '0;
      end else if (wb_valid_wb) begin
         instret <= instret + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: table-driven mux vectors, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mem_data_wb, alu_out_wb, pc4_wb, pcimm_wb;
   logic [4:0]  rd_wb;
   logic [1:0]  wb_mux_sel_wb;
   logic        reg_file_wr_wb, wb_valid_wb;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [31:0] rs1_data, rs2_data, wb_data;
   logic        wb_fwd_valid;
   logic [63:0] instret;
   logic [31:0] rs1_data4, rs2_data4, wb_data4;
   logic        wb_fwd_valid4;
   logic [3:0]  instret4;

   always #5 clk = ~clk;

   wb_regfile dut (
      .clk(clk), .rst(rst), .mem_data_wb(mem_data_wb), .alu_out_wb(alu_out_wb),
      .pc4_wb(pc4_wb), .pcimm_wb(pcimm_wb), .rd_wb(rd_wb),
      .wb_mux_sel_wb(wb_mux_sel_wb), .reg_file_wr_wb(reg_file_wr_wb),
      .wb_valid_wb(wb_valid_wb), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_data(wb_data),
      .wb_fwd_valid(wb_fwd_valid), .instret(instret)
   );

   wb_regfile #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .mem_data_wb(mem_data_wb), .alu_out_wb(alu_out_wb),
      .pc4_wb(pc4_wb), .pcimm_wb(pcimm_wb), .rd_wb(rd_wb),
      .wb_mux_sel_wb(wb_mux_sel_wb), .reg_file_wr_wb(reg_file_wr_wb),
      .wb_valid_wb(wb_valid_wb), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data4), .rs2_data(rs2_data4), .wb_data(wb_data4),
      .wb_fwd_valid(wb_fwd_valid4), .instret(instret4)
   );

   typedef struct {
      logic        rst;
      logic [31:0] alu, mem, pc4, pcimm;
      logic [4:0]  rd;
      logic [1:0]  sel;
      logic        wr, valid;
      logic [4:0]  a1, a2;
   } in_t;

   typedef struct {
      logic [1:0]  sel;
      logic [31:0] exp;
   } mux_vec_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_regs [32];
   logic [63:0] m_cnt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_wb();
      logic [31:0] src [4];
      src[0] = alu_out_wb; src[1] = mem_data_wb; src[2] = pc4_wb; src[3] = pcimm_wb;
      return src[wb_mux_sel_wb];
   endfunction

   function automatic logic [31:0] model_rd(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (reg_file_wr_wb && rd_wb == a) return model_wb();
      return m_regs[a];
   endfunction

   function automatic in_t idle(input logic [4:0] a1, input logic [4:0] a2);
      in_t v;
      v = '{rst: 1'b0, alu: 32'd0, mem: 32'd0, pc4: 32'd0, pcimm: 32'd0, rd: 5'd0,
            sel: 2'd0, wr: 1'b0, valid: 1'b0, a1: a1, a2: a2};
      return v;
   endfunction

   // Apply inputs half a cycle away from the active edge.
   task automatic drive(input in_t v);
      @(negedge clk);
      rst = v.rst; alu_out_wb = v.alu; mem_data_wb = v.mem; pc4_wb = v.pc4;
      pcimm_wb = v.pcimm; rd_wb = v.rd; wb_mux_sel_wb = v.sel;
      reg_file_wr_wb = v.wr; wb_valid_wb = v.valid; rs1_addr = v.a1; rs2_addr = v.a2;
      #1;
   endtask

   // Take the edge and advance the model with the inputs that were held.
   task automatic commit();
      @(posedge clk);
      if (rst) begin
         foreach (m_regs[i]) m_regs[i] = 32'd0;
         m_cnt = 64'd0;
      end else begin
         if (reg_file_wr_wb && rd_wb != 5'd0) m_regs[rd_wb] = model_wb();
         if (wb_valid_wb) m_cnt = m_cnt + 64'd1;
      end
      #1;
   endtask

   task automatic model_check();
      check("wb_data", wb_data, model_wb());
      check("wb_fwd_valid", wb_fwd_valid, reg_file_wr_wb && rd_wb != 5'd0);
      check("rs1_data", rs1_data, model_rd(rs1_addr));
      check("rs2_data", rs2_data, model_rd(rs2_addr));
      check("instret", instret, m_cnt);
      check("instret4", instret4, m_cnt % 64'd16);
   endtask

   task automatic cycle(input in_t v, input bit chk);
      drive(v);
      if (chk) model_check();
      commit();
   endtask

   function automatic in_t rand_in(input bit allow_rst);
      in_t v;
      v.rst   = allow_rst && ($urandom_range(0, 49) == 0);
      v.alu   = $urandom; v.mem = $urandom; v.pc4 = $urandom; v.pcimm = $urandom;
      v.rd    = 5'($urandom_range(0, 31));
      v.sel   = 2'($urandom_range(0, 3));
      v.wr    = ($urandom_range(0, 3) != 0);
      v.valid = ($urandom_range(0, 3) != 0);
      v.a1    = ($urandom_range(0, 2) == 0) ? v.rd : 5'($urandom_range(0, 31));
      v.a2    = ($urandom_range(0, 2) == 0) ? v.a1 : 5'($urandom_range(0, 31));
      return v;
   endfunction

   initial begin
      mux_vec_t tbl [4];
      in_t      v;

      tbl[0] = '{sel: 2'd0, exp: 32'h11};
      tbl[1] = '{sel: 2'd1, exp: 32'h22};
      tbl[2] = '{sel: 2'd2, exp: 32'h33};
      tbl[3] = '{sel: 2'd3, exp: 32'h44};

      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_cnt = 64'd0;

      // Reset after random writes: every register and the counter read 0.
      v = idle(5'd0, 5'd0); v.rst = 1'b1;
      cycle(v, 1'b0);
      for (int i = 0; i < 20; i++) cycle(rand_in(1'b0), 1'b1);
      v = idle(5'd0, 5'd0); v.rst = 1'b1; v.wr = 1'b1; v.rd = 5'd9; v.valid = 1'b1;
      cycle(v, 1'b0);
      cycle(v, 1'b0);
      for (int i = 0; i < 32; i++) begin
         drive(idle(5'(i), 5'(31 - i)));
         check("reset_rs1", rs1_data, 64'd0);
         check("reset_rs2", rs2_data, 64'd0);
         check("reset_instret", instret, 64'd0);
         commit();
      end

      // Mux select table and the later read of x5.
      for (int i = 0; i < 4; i++) begin
         v = idle(5'd5, 5'd0);
         v.alu = 32'h11; v.mem = 32'h22; v.pc4 = 32'h33; v.pcimm = 32'h44;
         v.rd = 5'd5; v.wr = 1'b1; v.sel = tbl[i].sel;
         drive(v);
         check("mux_wb_data", wb_data, tbl[i].exp);
         check("mux_fwd_valid", wb_fwd_valid, 64'd1);
         commit();
         drive(idle(5'd5, 5'd0));
         check("mux_read_x5", rs1_data, tbl[i].exp);
         commit();
      end

      // Same-cycle bypass to both ports, then array read after the edge.
      v = idle(5'd7, 5'd7); v.alu = 32'hDEADBEEF; v.rd = 5'd7; v.wr = 1'b1;
      drive(v);
      check("bypass_rs1", rs1_data, 64'hDEADBEEF);
      check("bypass_rs2", rs2_data, 64'hDEADBEEF);
      commit();
      drive(idle(5'd7, 5'd7));
      check("x7_rs1", rs1_data, 64'hDEADBEEF);
      check("x7_rs2", rs2_data, 64'hDEADBEEF);
      commit();

      // Writes to x0 are dropped and never forwarded.
      v = idle(5'd0, 5'd0); v.alu = 32'hFFFFFFFF; v.rd = 5'd0; v.wr = 1'b1;
      drive(v);
      check("x0_same_cycle", rs1_data, 64'd0);
      check("x0_fwd_valid", wb_fwd_valid, 64'd0);
      check("x0_wb_data", wb_data, 64'hFFFFFFFF);
      commit();
      drive(idle(5'd0, 5'd0));
      check("x0_after", rs1_data, 64'd0);
      commit();

      // Retire counting: 10 valid (6 writing, 4 not), 5 bubbles.
      v = idle(5'd0, 5'd0); v.rst = 1'b1;
      cycle(v, 1'b0);
      for (int i = 0; i < 15; i++) begin
         v = idle(5'd0, 5'd0);
         v.alu = $urandom; v.rd = 5'($urandom_range(1, 31));
         v.valid = (i % 3 != 2);
         v.wr = v.valid && (i < 9);
         cycle(v, 1'b0);
      end
      drive(idle(5'd0, 5'd0));
      check("retire_count", instret, 64'd10);
      commit();

      // Narrow counter wraps: 17 valid slots leave 1.
      v = idle(5'd0, 5'd0); v.rst = 1'b1;
      cycle(v, 1'b0);
      v = idle(5'd0, 5'd0); v.valid = 1'b1;
      for (int i = 0; i < 17; i++) cycle(v, 1'b0);
      drive(idle(5'd0, 5'd0));
      check("wrap_instret4", instret4, 64'd1);
      check("wrap_instret", instret, 64'd17);
      commit();

      // Reset wins over a simultaneous write and increment.
      v = idle(5'd0, 5'd0); v.alu = 32'hAAAA5555; v.rd = 5'd3; v.wr = 1'b1; v.valid = 1'b1;
      cycle(v, 1'b0);
      v.rst = 1'b1; v.alu = 32'h12345678;
      cycle(v, 1'b0);
      drive(idle(5'd3, 5'd3));
      check("rst_prio_x3", rs1_data, 64'd0);
      check("rst_prio_instret", instret, 64'd0);
      commit();

      // Randomized traffic, including occasional mid-stream resets.
      for (int i = 0; i < 400; i++) cycle(rand_in(1'b1), 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
